// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multi-cycle FETCH/EXECUTE/MEM sequencer for an RV32I core.
// Drives IR, register-file, PC and memory strobes; parks in HALT on SYSTEM opcodes or faults.
module rv_ctrl_fsm #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             take_branch,
  input  logic [1:0]       addr_lo,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [3:0]       mem_wmask,
  output logic             instr_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instret,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] F_NONE    = 2'd0;
  localparam logic [1:0] F_ILLEGAL = 2'd1;
  localparam logic [1:0] F_ALIGN   = 2'd2;
  localparam logic [1:0] F_TIMEOUT = 2'd3;

  // Counter only needs to reach WAIT_LIMIT-1; the next stalled cycle is the timeout.
  localparam int WC_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = (WAIT_LIMIT > 0) ? WC_W'(WAIT_LIMIT - 1) : '0;

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt;
  logic [1:0]      fault_d;
  logic            retire;
  logic [6:0]      opc;
  logic [1:0]      size;
  logic            rd_nz, is_store, aligned;
  logic            unused_instr;

  assign opc          = instr[6:0];
  assign size         = instr[13:12];
  assign rd_nz        = |instr[11:7];
  assign is_store     = (opc == OP_STORE);
  assign unused_instr = ^instr[31:14];
  assign state        = state_q;

  always_comb begin
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr_lo[0];
      2'd2:    aligned = (addr_lo == 2'd0);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fault_d   = fault;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_wmask = 4'b0000;
    instr_we  = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          instr_we = 1'b1;
          state_d  = S_EXEC;
        end
      end

      S_EXEC: begin
        case (opc)
          OP_REG, OP_IMM, OP_LUI, OP_AUIPC: begin
            rf_we   = rd_nz;
            wb_sel  = (opc == OP_LUI) ? 2'd3 : 2'd0;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            rf_we   = rd_nz;
            wb_sel  = 2'd2;
            pc_we   = 1'b1;
            pc_sel  = (opc == OP_JAL) ? 2'd1 : 2'd2;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = take_branch ? 2'd1 : 2'd0;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_LOAD, OP_STORE: begin
            if (size == 2'd3) begin
              state_d = S_HALT;
              fault_d = F_ILLEGAL;
            end else if (!aligned) begin
              state_d = S_HALT;
              fault_d = F_ALIGN;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_SYSTEM: begin
            state_d = S_HALT;
            fault_d = F_NONE;
          end
          default: begin
            state_d = S_HALT;
            fault_d = F_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_wr  = is_store;
        if (is_store) begin
          case (size)
            2'd0:    mem_wmask = 4'b0001 << addr_lo;
            2'd1:    mem_wmask = 4'b0011 << {addr_lo[1], 1'b0};
            default: mem_wmask = 4'b1111;
          endcase
        end
        if (mem_ready) begin
          rf_we   = !is_store && rd_nz;
          wb_sel  = is_store ? 2'd0 : 2'd1;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      default: ;
    endcase

    // A ready on the limit cycle has already advanced the state above and wins.
    if (WAIT_LIMIT != 0 && mem_req && !mem_ready && wait_cnt == WC_LAST) begin
      state_d = S_HALT;
      fault_d = F_TIMEOUT;
    end

    if (rst) begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_wmask = 4'b0000;
      instr_we  = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      retire    = 1'b0;
      state_d   = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      halted   <= 1'b0;
      fault    <= F_NONE;
      instret  <= '0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == S_HALT);
      fault   <= fault_d;
      if (retire) instret <= instret + 1'b1;
      if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Bench for rv_ctrl_fsm: directed instruction sequences, a phase-level reference model checked
// on every falling edge, and hand-computed spot checks that pin the model.
`timescale 1ns/1ps
module tb_rv_ctrl_fsm;
  localparam int WL = 16;
  localparam int CW = 32;

  localparam logic [31:0] I_ADDI   = 32'h00100093;
  localparam logic [31:0] I_LW     = 32'h0000A103;
  localparam logic [31:0] I_SB     = 32'h00208023;
  localparam logic [31:0] I_SW     = 32'h0020A023;
  localparam logic [31:0] I_BEQ    = 32'h00000063;
  localparam logic [31:0] I_JAL0   = 32'h0000006F;
  localparam logic [31:0] I_EBREAK = 32'h00100073;
  localparam logic [31:0] I_FENCE  = 32'h0000000F;
  localparam logic [31:0] I_LBAD   = 32'h0000B103;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   instr = '0;
  logic          take_branch = 1'b0;
  logic [1:0]    addr_lo = '0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_wr, instr_we, rf_we, pc_we, halted;
  logic [3:0]    mem_wmask;
  logic [1:0]    wb_sel, pc_sel, fault, state;
  logic [CW-1:0] instret;

  int checks = 0;
  int failures = 0;

  rv_ctrl_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .take_branch(take_branch), .addr_lo(addr_lo),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_wr(mem_wr), .mem_wmask(mem_wmask),
    .instr_we(instr_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .fault(fault), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase 0 fetch, 1 execute, 2 memory, 3 halted.
  int     m_ph, m_stall, m_fault;
  bit     m_halted, m_valid;
  longint m_ret;

  initial begin : cmp
    bit e_req, e_wr, e_iwe, e_rf, e_pcwe, retire;
    int e_mask, e_wb, e_pcs, n_ph, n_stall, n_fault, op, rd, sz;
    m_valid = 1'b0;
    forever begin
      @(negedge clk);
      n_ph = m_ph; n_fault = m_fault; n_stall = 0; retire = 1'b0;
      e_req = 0; e_wr = 0; e_iwe = 0; e_rf = 0; e_pcwe = 0;
      e_mask = 0; e_wb = 0; e_pcs = 0;
      op = int'(instr[6:0]); rd = int'(instr[11:7]); sz = 1 << instr[13:12];
      if (m_valid && !rst) begin
        if (m_ph == 0) begin
          e_req = 1;
          if (mem_ready) begin e_iwe = 1; n_ph = 1; end
        end else if (m_ph == 1) begin
          case (op)
            'h33, 'h13, 'h37, 'h17: begin
              e_rf = (rd != 0); e_wb = (op == 'h37) ? 3 : 0;
              e_pcwe = 1; e_pcs = 0; retire = 1; n_ph = 0;
            end
            'h6F, 'h67: begin
              e_rf = (rd != 0); e_wb = 2; e_pcwe = 1;
              e_pcs = (op == 'h6F) ? 1 : 2; retire = 1; n_ph = 0;
            end
            'h63: begin e_pcwe = 1; e_pcs = take_branch ? 1 : 0; retire = 1; n_ph = 0; end
            'h03, 'h23: begin
              if (sz == 8) begin n_ph = 3; n_fault = 1; end
              else if ((int'(addr_lo) % sz) != 0) begin n_ph = 3; n_fault = 2; end
              else n_ph = 2;
            end
            'h73: begin n_ph = 3; n_fault = 0; end
            default: begin n_ph = 3; n_fault = 1; end
          endcase
        end else if (m_ph == 2) begin
          e_req = 1;
          e_wr = (op == 'h23);
          if (e_wr) e_mask = ((1 << sz) - 1) << addr_lo;
          if (mem_ready) begin
            e_rf = !e_wr && (rd != 0); e_wb = 1;
            e_pcwe = 1; e_pcs = 0; retire = 1; n_ph = 0;
          end
        end
        if (e_req && !mem_ready) begin
          n_stall = m_stall + 1;
          if (n_stall == WL) begin n_ph = 3; n_fault = 3; end
        end
      end
      if (m_valid) begin
        chk("mdl_mem_req", mem_req, e_req);
        chk("mdl_instr_we", instr_we, e_iwe);
        chk("mdl_rf_we", rf_we, e_rf);
        chk("mdl_pc_we", pc_we, e_pcwe);
        if (e_req) begin
          chk("mdl_mem_wr", mem_wr, e_wr);
          chk("mdl_mem_wmask", mem_wmask, e_mask);
        end
        if (e_rf) chk("mdl_wb_sel", wb_sel, e_wb);
        if (e_pcwe) chk("mdl_pc_sel", pc_sel, e_pcs);
        chk("mdl_state", state, m_ph);
        chk("mdl_halted", halted, m_halted);
        chk("mdl_fault", fault, m_fault);
        chk("mdl_instret", instret, m_ret);
      end
      @(posedge clk);
      if (rst) begin
        m_ph = 0; m_stall = 0; m_fault = 0; m_halted = 0; m_ret = 0; m_valid = 1'b1;
      end else if (m_valid) begin
        m_ph = n_ph; m_stall = n_stall; m_fault = n_fault; m_halted = (n_ph == 3);
        if (retire) m_ret = (m_ret + 1) % (longint'(1) << CW);
      end
    end
  end

  // Run one non-faulting instruction from FETCH back to FETCH with memory always ready.
  task automatic run_op(input logic [31:0] ins, input logic [1:0] al, input bit is_mem);
    instr = ins; addr_lo = al; mem_ready = 1'b1;
    step();
    if (is_mem) step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin : wdog
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int n, seen;
    rst = 1'b1; mem_ready = 1'b1;
    repeat (3) step();
    #1 chk("rst_mem_req", mem_req, 0);
    chk("rst_instr_we", instr_we, 0);

    // addi x1,x0,1
    step();
    rst = 1'b0; instr = I_ADDI;
    #1 chk("reset_state", state, 0);
    chk("reset_instret", instret, 0);
    chk("reset_halted", halted, 0);
    chk("reset_fault", fault, 0);
    chk("t1_fetch_req", mem_req, 1);
    chk("t1_fetch_iwe", instr_we, 1);
    step();
    #1 chk("t1_rf_we", rf_we, 1);
    chk("t1_wb_sel", wb_sel, 0);
    chk("t1_pc_we", pc_we, 1);
    chk("t1_pc_sel", pc_sel, 0);
    step();
    instr = I_LW; addr_lo = 2'd0;
    #1 chk("t1_instret", instret, 1);

    // lw with three not-ready cycles
    step();
    mem_ready = 1'b0;
    #1 chk("t2_exec_noreq", mem_req, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1 chk("t2_mem_req", mem_req, 1);
      chk("t2_rf_we", rf_we, (i == 3));
      if (i == 3) chk("t2_wb_sel", wb_sel, 1);
      step();
    end
    instr = I_SB; addr_lo = 2'd2; mem_ready = 1'b1;
    #1 chk("t2_instret", instret, 2);

    // sb at byte 2, then misaligned sw
    step();
    step();
    #1 chk("t3_sb_wmask", mem_wmask, 4'b0100);
    chk("t3_sb_wr", mem_wr, 1);
    step();
    instr = I_SW; addr_lo = 2'd1;
    #1 chk("t3_instret", instret, 3);
    step();
    #1 chk("t3_sw_noreq", mem_req, 0);
    step();
    #1 chk("t3_halted", halted, 1);
    chk("t3_fault", fault, 2);
    chk("t3_halt_noreq", mem_req, 0);

    // branches and jumps
    do_reset();
    instr = I_BEQ; take_branch = 1'b1; mem_ready = 1'b1;
    step();
    #1 chk("t4_bt_pc_we", pc_we, 1);
    chk("t4_bt_pc_sel", pc_sel, 1);
    chk("t4_bt_rf_we", rf_we, 0);
    step();
    take_branch = 1'b0;
    step();
    #1 chk("t4_bn_pc_we", pc_we, 1);
    chk("t4_bn_pc_sel", pc_sel, 0);
    chk("t4_bn_rf_we", rf_we, 0);
    step();
    instr = I_JAL0;
    step();
    #1 chk("t4_jal0_rf_we", rf_we, 0);
    chk("t4_jal0_pc_sel", pc_sel, 1);
    step();
    run_op(32'h000000EF, 2'd0, 1'b0);  // jal x1
    run_op(32'h000100E7, 2'd0, 1'b0);  // jalr x1,0(x2)
    run_op(32'h000002B7, 2'd0, 1'b0);  // lui x5
    run_op(32'h00000297, 2'd0, 1'b0);  // auipc x5
    run_op(32'h00009103, 2'd2, 1'b1);  // lh x2 at offset 2
    run_op(32'h00209023, 2'd2, 1'b1);  // sh at offset 2
    run_op(32'h00008103, 2'd3, 1'b1);  // lb at offset 3
    run_op(32'h00000033, 2'd0, 1'b0);  // add x0 (rd=0)
    #1 chk("t4_instret", instret, 11);

    // ebreak halts without retiring; only reset leaves
    instr = I_EBREAK; mem_ready = 1'b1;
    step();
    #1 chk("t5_exec_noreq", mem_req, 0);
    step();
    #1 chk("t5_halted", halted, 1);
    chk("t5_fault", fault, 0);
    chk("t5_instret", instret, 11);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1 if (mem_req) seen++;
      step();
    end
    chk("t5_no_req_100", seen, 0);
    chk("t5_still_halt", state, 3);
    do_reset();
    mem_ready = 1'b0; instr = I_ADDI;
    #1 chk("t5_rst_state", state, 0);
    chk("t5_rst_instret", instret, 0);

    // fetch timeout after exactly WL stalled cycles
    n = 0;
    while (state != 2'd3 && n < 40) begin step(); n++; end
    chk("t6_fetch_timeout_cycles", n, WL);
    chk("t6_fetch_fault", fault, 3);

    // ready on the limit cycle wins
    do_reset();
    mem_ready = 1'b0;
    repeat (WL - 1) step();
    mem_ready = 1'b1;
    step();
    #1 chk("t6_ready_wins_state", state, 1);
    chk("t6_ready_wins_halted", halted, 0);
    step();
    instr = I_LW; addr_lo = 2'd0;
    step();
    mem_ready = 1'b0;
    step();
    n = 0;
    while (state != 2'd3 && n < 40) begin step(); n++; end
    chk("t6_mem_timeout_cycles", n, WL);
    chk("t6_mem_fault", fault, 3);

    // reset in the middle of a memory wait
    do_reset();
    instr = I_LW; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1 chk("t6_rst_drop_req", mem_req, 0);
    step();
    rst = 1'b0;
    #1 chk("t6_rst_fetch", state, 0);
    chk("t6_rst_fetch_req", mem_req, 1);

    // illegal opcode and illegal load width
    instr = I_FENCE; mem_ready = 1'b1;
    step();
    step();
    #1 chk("t7_fence_fault", fault, 1);
    chk("t7_fence_halted", halted, 1);
    do_reset();
    instr = I_LBAD; mem_ready = 1'b1;
    step();
    step();
    #1 chk("t7_ldwidth_fault", fault, 1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
